uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity by default. It sits between the asynchronous `serial_in` pin and the byte-consuming logic. It synchronizes the line, validates the start bit at mid-bit, samples each bit at its centre and presents each good byte with a one-cycle `data_valid` strobe. Bad stop bits, and bad parity when parity is compiled in, are flagged instead.

## Interface
- `CLOCKS_PER_BIT`, default 217: clock cycles per bit period. Legal range 4..65535.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `serial_in` input 1: asynchronous UART line; idle high.
- `data_out` output 8: last correctly received byte.
- `data_valid` output 1: one-cycle pulse when `data_out` is updated.
- `receiving` output 1: high while a frame is being received.
- `framing_error` output 1: one-cycle pulse when the stop bit samples low.
- `parity_error` output 1: one-cycle pulse on a parity mismatch. Tied to 0 when parity is compiled out.

## Operation
- Synchronizer: two flops, both reset to 1. `rx_s` is the second stage. All decisions use `rx_s` only.
- Internal registers:
  - bit counter, 16 bits wide.
  - `bit_index`, 3 bits.
  - shift register, 8 bits.
- `H` = (`CLOCKS_PER_BIT` − 1) / 2, integer division.
- States:
  - IDLE: counter = 0, `bit_index` = 0, `receiving` = 0. If `rx_s` = 0, go to START_BIT and set `receiving` = 1.
  - START_BIT: counter increments each cycle. When counter = H, check `rx_s`:
    - `rx_s` = 0: clear counter, go to DATA_BITS.
    - `rx_s` = 1: treat as a glitch. Go to IDLE with no flag and `receiving` = 0.
  - DATA_BITS: counter increments. When counter = `CLOCKS_PER_BIT` − 1:
    - store `rx_s` into shift register bit [`bit_index`] and clear the counter.
    - if `bit_index` < 7, increment it.
    - otherwise clear `bit_index` and go to STOP_BIT (PARITY_BIT when parity is enabled).
  - PARITY_BIT (parity builds only): at counter = `CLOCKS_PER_BIT` − 1, latch `rx_s` as the parity sample, clear the counter, go to STOP_BIT.
  - STOP_BIT: at counter = `CLOCKS_PER_BIT` − 1, evaluate the stop bit and go to IDLE with `receiving` = 0:
    - `rx_s` = 1 and parity OK (or parity absent): load `data_out` from the shift register and pulse `data_valid`.
    - `rx_s` = 0: pulse `framing_error` only. `data_out` is unchanged. Framing error takes precedence over parity error.
    - `rx_s` = 1 but parity bad: pulse `parity_error`. `data_out` is unchanged and `data_valid` stays 0.
  - Illegal state encoding: go to IDLE on the next cycle.
- The receiver returns to IDLE at the centre of the stop bit. This allows back-to-back frames with zero idle time.
- A line held low (break): framing error, then an immediate new start detection that passes validation. The frame repeats until the line goes high.

## Timing
- Reset values:
  - `data_out` = 0x00.
  - `data_valid`, `receiving`, `framing_error`, `parity_error` = 0.
  - synchronizer flops = 1.
  - state = IDLE, counter = 0, `bit_index` = 0.
- Reset asserted mid-frame: all of the above take effect immediately. The partial byte is discarded. No strobe fires after release.
- Define edge T as the first rising edge that samples `serial_in` low. Then:
  - `rx_s` is low after T+1.
  - START_BIT is entered at T+2.
  - Start validation happens at T+3+H.
  - Data bit n is sampled at T+3+H+(n+1)·`CLOCKS_PER_BIT`.
  - The stop bit is sampled at T+3+H+9·`CLOCKS_PER_BIT` (+`CLOCKS_PER_BIT` with parity).
  - `data_valid`, `framing_error` or `parity_error` is high for exactly the one cycle after that edge.
- `receiving` rises at T+2 and falls at the same edge that raises the strobe.
- `data_out` is stable from the strobe until the next good frame.
- No handshake or backpressure: a consumer that misses the strobe may still read `data_out` until the next good frame.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a PARITY_BIT state is inserted after data bit 7. Parity is even: the XOR of the 8 data bits and the parity sample must be 0. A mismatch pulses `parity_error`. Frame length is 11 bit periods.
  - Undefined: no PARITY_BIT state and no parity logic. `parity_error` is constant 0. Frame length is 10 bit periods.

## Test plan
All scenarios use `CLOCKS_PER_BIT` = 16, so H = 7.
- Byte 0xA5 sent, line idle high before and after → `data_valid` is high for one cycle after edge T+154, `data_out` = 0xA5, `receiving` is high from T+2 up to that edge, no error flags.
- Frames 0x00, 0xFF and 0x3C back-to-back, no idle gap → three `data_valid` pulses 160 cycles apart with the correct bytes, no errors.
- 5-cycle low glitch on an idle line → return to IDLE at T+10, `receiving` pulses for 8 cycles, no `data_valid`, no `framing_error`.
- Byte 0x55 with the stop bit driven low → `framing_error` pulse at the `data_valid` slot; `data_out` keeps its previous value; the next good frame 0x81 is received correctly.
- Reset asserted at data bit 4, line then idle → all outputs 0 immediately, no strobe after release; the next frame 0x12 is received correctly.
- With `UART_RX_PARITY_EN`:
  - 0x07 sent with parity bit 1 → `data_valid`.
  - 0x07 sent with parity bit 0 → `parity_error` pulse after edge T+170, no `data_valid`.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8-bit LSB-first UART receiver with a two-flop synchronizer, mid-bit start validation and centre sampling.
// Define UART_RX_PARITY_EN to insert an even-parity bit after data bit 7 and drive parity_error.
module uart_rx_core #(
  parameter int unsigned CLOCKS_PER_BIT = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       receiving,
  output logic       framing_error,
  output logic       parity_error
);
  localparam logic [15:0] CNT_LAST = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF = 16'((CLOCKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
`endif

  state_t      state_q, state_d;
  logic        meta_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        recv_q, recv_d;
  logic        rx_s;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  assign rx_s = rx_s_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      recv_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      meta_q      <= serial_in;
      rx_s_q      <= meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      recv_q      <= recv_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_q      <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    recv_d      = recv_q;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    perr_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        bit_index_d = '0;
        recv_d      = 1'b0;
        if (!rx_s) begin
          state_d = START_BIT;
          recv_d  = 1'b1;
        end
      end
      START_BIT: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          if (!rx_s) begin
            state_d = DATA_BITS;
          end else begin
            state_d = IDLE;
            recv_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_index_q] = rx_s;
          if (bit_index_q != 3'd7) begin
            bit_index_d = bit_index_q + 3'd1;
          end else begin
            bit_index_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d     = PARITY_BIT;
`else
            state_d     = STOP_BIT;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP_BIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          recv_d  = 1'b0;
          // Framing error wins over parity error; data_out only moves on a clean frame.
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        bit_index_d = '0;
        recv_d      = 1'b0;
      end
    endcase
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign receiving     = recv_q;
  assign framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at CLOCKS_PER_BIT = 16: frame-level schedule model checked every cycle plus literal slot checks.
// Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;
  localparam int CPB  = 16;
  localparam int H    = (CPB - 1) / 2;
  localparam int NCYC = 4096;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR        = 1'b1;
  localparam int STROBE_OFS = 170;
`else
  localparam bit PAR        = 1'b0;
  localparam int STROBE_OFS = 154;
`endif
  localparam int FRAME = (10 + int'(PAR)) * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, receiving, framing_error, parity_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Expected per-cycle outputs, indexed by the number of rising edges seen.
  bit         exp_recv [NCYC];
  bit         exp_dv   [NCYC];
  bit         exp_fe   [NCYC];
  bit         exp_pe   [NCYC];
  bit         upd_en   [NCYC];
  logic [7:0] upd_val  [NCYC];
  logic [7:0] model_data = 8'h00;

  int         dv_cyc[$];
  logic [7:0] dv_byte[$];
  int         fe_cyc[$];
  logic [7:0] fe_byte[$];
  int         pe_cyc[$];
  int         recv_cnt = 0;

  uart_rx_core #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .receiving    (receiving),
    .framing_error(framing_error),
    .parity_error (parity_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  task automatic model_glitch(input int t);
    for (int i = t + 2; i <= t + 2 + H; i++)
      if (i < NCYC) exp_recv[i] = 1'b1;
  endtask

  // A frame whose line goes low at edge t resolves one stop-bit centre later.
  task automatic model_frame(input int t, input logic [7:0] b, input bit stop, input bit p);
    int s;
    s = t + 3 + H + (9 + int'(PAR)) * CPB;
    for (int i = t + 2; i < s; i++)
      if (i < NCYC) exp_recv[i] = 1'b1;
    if (s < NCYC) begin
      if (!stop) begin
        exp_fe[s] = 1'b1;
        model_glitch(s - 1);
      end else if (PAR && ((^b) ^ p)) begin
        exp_pe[s] = 1'b1;
      end else begin
        exp_dv[s]  = 1'b1;
        upd_en[s]  = 1'b1;
        upd_val[s] = b;
      end
    end
  endtask

  task automatic model_reset(input int c);
    for (int i = c; i < NCYC; i++) begin
      exp_recv[i] = 1'b0;
      exp_dv[i]   = 1'b0;
      exp_fe[i]   = 1'b0;
      exp_pe[i]   = 1'b0;
      upd_en[i]   = 1'b0;
    end
    model_data = 8'h00;
  endtask

  always @(negedge clock) begin : compare
    logic [11:0] ev, av;
    if (cyc < NCYC) begin
      if (upd_en[cyc]) model_data = upd_val[cyc];
      ev = {exp_recv[cyc], exp_dv[cyc], exp_fe[cyc], exp_pe[cyc], model_data};
      av = {receiving, data_valid, framing_error, parity_error, data_out};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d got recv/dv/fe/pe/data=%03h expected %03h", cyc, av, ev);
      end
    end
    if (data_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_byte.push_back(data_out);
    end
    if (framing_error === 1'b1) begin
      fe_cyc.push_back(cyc);
      fe_byte.push_back(data_out);
    end
    if (parity_error === 1'b1) pe_cyc.push_back(cyc);
    if (receiving === 1'b1) recv_cnt++;
  end

  task automatic clear_obs();
    dv_cyc.delete();
    dv_byte.delete();
    fe_cyc.delete();
    fe_byte.delete();
    pe_cyc.delete();
    recv_cnt = 0;
  endtask

  task automatic drive_bit(input bit v);
    serial_in = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit p, output int t);
    t = cyc + 1;
    model_frame(t, b, stop, p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit(p);
    drive_bit(stop);
    $display("tx frame byte=0x%02h stop=%0b par=%0b T=%0d", b, stop, p, t);
  endtask

  initial begin : stim
    int t, t1;
    logic [7:0] c3;
    c3 = 8'hC3;
    repeat (4) @(posedge clock);
    #1;
    chk("reset_state", {receiving, data_valid, framing_error, parity_error, data_out}, 0);
    reset = 1'b1;
    idle(20);

    // Single byte
    clear_obs();
    send_frame(8'hA5, 1'b1, 1'b0, t);
    idle(20);
    chk("a5_pulses", dv_cyc.size(), 1);
    if (dv_cyc.size() > 0) begin
      chk("a5_slot", dv_cyc[0] - t, STROBE_OFS);
      chk("a5_byte", dv_byte[0], 8'hA5);
    end
    chk("a5_recv_len", recv_cnt, STROBE_OFS - 2);

    // Back-to-back frames
    clear_obs();
    send_frame(8'h00, 1'b1, 1'b0, t);
    send_frame(8'hFF, 1'b1, 1'b0, t);
    send_frame(8'h3C, 1'b1, 1'b0, t);
    idle(20);
    chk("b2b_pulses", dv_cyc.size(), 3);
    if (dv_cyc.size() == 3) begin
      chk("b2b_gap1", dv_cyc[1] - dv_cyc[0], FRAME);
      chk("b2b_gap2", dv_cyc[2] - dv_cyc[1], FRAME);
      chk("b2b_byte0", dv_byte[0], 8'h00);
      chk("b2b_byte1", dv_byte[1], 8'hFF);
      chk("b2b_byte2", dv_byte[2], 8'h3C);
    end
    chk("b2b_no_fe", fe_cyc.size(), 0);

    // Start-bit glitch
    clear_obs();
    t = cyc + 1;
    model_glitch(t);
    serial_in = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    $display("tx glitch 5 cycles T=%0d", t);
    idle(40);
    chk("glitch_recv_len", recv_cnt, 8);
    chk("glitch_no_dv", dv_cyc.size(), 0);
    chk("glitch_no_fe", fe_cyc.size(), 0);

    // Bad stop bit, then a good frame
    clear_obs();
    send_frame(8'h55, 1'b0, 1'b1, t);
    idle(40);
    chk("fe_pulses", fe_cyc.size(), 1);
    if (fe_cyc.size() > 0) begin
      chk("fe_slot", fe_cyc[0] - t, STROBE_OFS);
      chk("fe_data_kept", fe_byte[0], 8'h3C);
    end
    chk("fe_no_dv", dv_cyc.size(), 0);
    chk("fe_no_pe", pe_cyc.size(), 0);
    send_frame(8'h81, 1'b1, 1'b0, t);
    idle(20);
    chk("after_fe_pulses", dv_cyc.size(), 1);
    if (dv_cyc.size() > 0) chk("after_fe_byte", dv_byte[0], 8'h81);

    // Reset in the middle of data bit 4
    clear_obs();
    t = cyc + 1;
    model_frame(t, c3, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    serial_in = c3[4];
    repeat (CPB / 2) @(posedge clock);
    #1;
    chk("recv_before_reset", receiving, 1);
    reset = 1'b0;
    model_reset(cyc);
    serial_in = 1'b1;
    #1;
    chk("reset_immediate", {receiving, data_valid, framing_error, parity_error, data_out}, 0);
    $display("reset asserted mid-frame T=%0d cyc=%0d", t, cyc);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    clear_obs();
    idle(200);
    chk("reset_no_dv", dv_cyc.size(), 0);
    chk("reset_no_fe", fe_cyc.size(), 0);
    send_frame(8'h12, 1'b1, 1'b0, t);
    idle(20);
    chk("after_reset_pulses", dv_cyc.size(), 1);
    if (dv_cyc.size() > 0) chk("after_reset_byte", dv_byte[0], 8'h12);

`ifdef UART_RX_PARITY_EN
    clear_obs();
    send_frame(8'h07, 1'b1, 1'b1, t);
    idle(20);
    chk("par_ok_pulses", dv_cyc.size(), 1);
    if (dv_cyc.size() > 0) chk("par_ok_byte", dv_byte[0], 8'h07);
    chk("par_ok_no_pe", pe_cyc.size(), 0);
    clear_obs();
    send_frame(8'h07, 1'b1, 1'b0, t);
    idle(20);
    chk("par_bad_pe", pe_cyc.size(), 1);
    if (pe_cyc.size() > 0) chk("par_bad_slot", pe_cyc[0] - t, 170);
    chk("par_bad_no_dv", dv_cyc.size(), 0);
`endif

    t1 = cyc;
    $display("run ended at cycle %0d", t1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
